// File: rtl/gfx_pkg.sv
// Shared definitions for the GfxDma command queue: DMA register map, CTRL layout,
// sequencer state encoding and descriptor byte access.
package gfx_pkg;

    typedef enum logic [2:0] {
        SRC_L  = 3'd0,
        SRC_H  = 3'd1,
        DST_L  = 3'd2,
        DST_H  = 3'd3,
        WIDTH  = 3'd4,
        HEIGHT = 3'd5,
        MASK   = 3'd6,
        STATE  = 3'd7
    } dma_reg_e;

    localparam logic [3:0] CTRL_ADDR        = 4'd8;
    localparam int         CTRL_FLUSH_BIT   = 0;
    localparam int         CTRL_CLR_OVF_BIT = 1;
    localparam logic [7:0] MASK_RESET       = 8'hFF;

    localparam logic [1:0] SEQ_IDLE       = 2'd0;
    localparam logic [1:0] SEQ_WRITE      = 2'd1;
    localparam logic [1:0] SEQ_WAIT_START = 2'd2;
    localparam logic [1:0] SEQ_WAIT_DONE  = 2'd3;

    // Byte 0 (SRC_L) sits in the top byte, STATE in the bottom byte.
    typedef logic [63:0] desc_t;

    function automatic logic [7:0] desc_byte(input desc_t desc, input logic [2:0] idx);
        return desc[{~idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/gfx_desc_fifo.sv
// Synchronous descriptor FIFO with flush; level, full and empty are registered so
// they reflect the pushes and pops of the previous edge.
module gfx_desc_fifo
    import gfx_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  desc_t                 i_push_data,
    input  logic                  i_pop,
    input  logic                  i_flush,
    output desc_t                 o_head,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_drop
);

    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

    desc_t                 mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  pop_ok;
    logic                  push_ok;

    assign pop_ok  = i_pop && !empty_q;
    // A same-edge pop or flush frees room, so a push into a full queue survives it.
    assign push_ok = i_push && (!full_q || pop_ok || i_flush);

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (i_flush) begin
            rd_ptr_d = wr_ptr_q;
            level_d  = '0;
        end else if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            level_d  = level_q - 1'b1;
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            level_d  = level_d + 1'b1;
        end
        full_d  = (level_d == FULL_LEVEL);
        empty_d = (level_d == '0);
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // NOTE: the storage array is not reset; the pointers and level define validity.
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= i_push_data;
        end
    end

    assign o_head  = mem_q[rd_ptr_q];
    assign o_level = level_q;
    assign o_full  = full_q;
    assign o_empty = empty_q;
    assign o_drop  = i_push && !push_ok;

endmodule

// File: rtl/gfx_blit_queue.sv
// CPU-facing blit command queue: stages 8-byte descriptors, queues them, and replays
// each into the GfxDma register map (STATE last), waiting for the DMA between blits.
module gfx_blit_queue
    import gfx_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int DEPTH_LOG2    = 2,
    parameter int START_TIMEOUT = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cpu_we,
    input  logic [3:0]            i_cpu_addr,
    input  logic [7:0]            i_cpu_data,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_busy,
    output logic                  o_overflow,
    output logic                  o_dma_ce_b,
    output logic                  o_dma_we_b,
    output logic [2:0]            o_dma_addr,
    output logic [7:0]            o_dma_data,
    output logic                  o_dma_drive,
    input  logic                  i_dma_active
);

    localparam int                   TIMER_W      = $clog2(START_TIMEOUT) + 1;
    localparam logic [TIMER_W-1:0]   TIMEOUT_LAST = TIMER_W'(START_TIMEOUT - 1);

    logic [7:0]         staging_q [8];
    logic [7:0]         staging_d [8];
    logic [1:0]         state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    desc_t              shadow_q, shadow_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               overflow_q, overflow_d;
    logic               busy_q, busy_d;
    logic               dma_ce_b_q, dma_ce_b_d;
    logic               dma_we_b_q, dma_we_b_d;
    logic               dma_drive_q, dma_drive_d;
    logic [2:0]         dma_addr_q, dma_addr_d;
    logic [7:0]         dma_data_q, dma_data_d;

    logic               cpu_stage;
    logic               cpu_push;
    logic               cpu_ctrl;
    logic               flush;
    logic               clr_ovf;
    desc_t              push_data;
    logic               pop;
    logic               writing;
    desc_t              fifo_head;
    logic               fifo_empty;
    logic               fifo_drop;

    assign cpu_stage = i_cpu_we && !i_cpu_addr[3];
    assign cpu_push  = cpu_stage && (i_cpu_addr[2:0] == STATE);
    assign cpu_ctrl  = i_cpu_we && (i_cpu_addr == CTRL_ADDR);
    assign flush     = cpu_ctrl && i_cpu_data[CTRL_FLUSH_BIT];
    assign clr_ovf   = cpu_ctrl && i_cpu_data[CTRL_CLR_OVF_BIT];
    assign push_data = {staging_q[0], staging_q[1], staging_q[2], staging_q[3],
                        staging_q[4], staging_q[5], staging_q[6], i_cpu_data};

    gfx_desc_fifo #(
        .DEPTH      (DEPTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (cpu_push),
        .i_push_data (push_data),
        .i_pop       (pop),
        .i_flush     (flush),
        .o_head      (fifo_head),
        .o_level     (o_level),
        .o_full      (o_full),
        .o_empty     (fifo_empty),
        .o_drop      (fifo_drop)
    );

    always_comb begin
        staging_d = staging_q;
        if (cpu_stage) begin
            staging_d[i_cpu_addr[2:0]] = i_cpu_data;
        end
        overflow_d = overflow_q;
        if (fifo_drop) begin
            overflow_d = 1'b1;
        end
        if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        timer_d  = timer_q;
        pop      = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                if (!fifo_empty && !i_dma_active) begin
                    pop      = 1'b1;
                    shadow_d = fifo_head;
                    idx_d    = SRC_L;
                    state_d  = SEQ_WRITE;
                end
            end
            SEQ_WRITE: begin
                idx_d = idx_q + 3'd1;
                if (idx_q == STATE) begin
                    state_d = SEQ_WAIT_START;
                    timer_d = '0;
                end
            end
            SEQ_WAIT_START: begin
                if (i_dma_active) begin
                    state_d = SEQ_WAIT_DONE;
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d = SEQ_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            SEQ_WAIT_DONE: begin
                if (!i_dma_active) begin
                    state_d = SEQ_IDLE;
                end
            end
            default: state_d = SEQ_IDLE;
        endcase

        // Bus flops are loaded from the next state so they line up with state_q.
        writing     = (state_d == SEQ_WRITE);
        dma_ce_b_d  = !writing;
        dma_we_b_d  = !writing;
        dma_drive_d = writing;
        dma_addr_d  = writing ? idx_d : 3'd0;
        dma_data_d  = writing ? desc_byte(shadow_d, idx_d) : 8'h00;
        busy_d      = (state_d != SEQ_IDLE) || i_dma_active;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            staging_q   <= '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, MASK_RESET, 8'h00};
            state_q     <= SEQ_IDLE;
            idx_q       <= '0;
            shadow_q    <= '0;
            timer_q     <= '0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
            dma_ce_b_q  <= 1'b1;
            dma_we_b_q  <= 1'b1;
            dma_drive_q <= 1'b0;
            dma_addr_q  <= '0;
            dma_data_q  <= '0;
        end else begin
            staging_q   <= staging_d;
            state_q     <= state_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            timer_q     <= timer_d;
            overflow_q  <= overflow_d;
            busy_q      <= busy_d;
            dma_ce_b_q  <= dma_ce_b_d;
            dma_we_b_q  <= dma_we_b_d;
            dma_drive_q <= dma_drive_d;
            dma_addr_q  <= dma_addr_d;
            dma_data_q  <= dma_data_d;
        end
    end

    assign o_empty     = fifo_empty;
    assign o_busy      = busy_q;
    assign o_overflow  = overflow_q;
    assign o_dma_ce_b  = dma_ce_b_q;
    assign o_dma_we_b  = dma_we_b_q;
    assign o_dma_drive = dma_drive_q;
    assign o_dma_addr  = dma_addr_q;
    assign o_dma_data  = dma_data_q;

endmodule

// File: doc/gfx_blit_queue.md
Name: gfx_blit_queue

Overview:
Command queue directly upstream of the GfxDma block. The CPU writes complete 8-byte blit descriptors into a FIFO. A sequencer replays each descriptor into the DMA control registers 0x00–0x07, ending with STATE, which starts the DMA. It then waits for the DMA to finish before issuing the next descriptor, so the CPU can queue several blits without polling o_active.

Parameters:
DEPTH, 4, number of descriptor slots; power of two, minimum 2.
DEPTH_LOG2, 2, log2(DEPTH).
START_TIMEOUT, 4, cycles to wait for i_dma_active to rise after the STATE write.

Ports:
i_clk  in  1  system clock, 25.175 MHz, same clock as GfxDma i_clk.
i_rst  in  1  reset, synchronous, active-high.
i_cpu_we  in  1  CPU write strobe; one write per cycle while high.
i_cpu_addr  in  4  0–7: descriptor staging bytes (DMA register map); 8: CTRL.
i_cpu_data  in  8  CPU write data.
o_level  out  DEPTH_LOG2+1  number of queued descriptors, excluding the one in flight.
o_full  out  1  o_level == DEPTH.
o_empty  out  1  o_level == 0.
o_busy  out  1  sequencer not IDLE, or i_dma_active high.
o_overflow  out  1  sticky; set when a push is dropped because the queue is full.
o_dma_ce_b  out  1  to GfxDma i_src_ce_b; low only in WRITE state.
o_dma_we_b  out  1  to GfxDma io_src_we_b; low only in WRITE state.
o_dma_addr  out  3  to GfxDma io_src_addr[2:0].
o_dma_data  out  8  to GfxDma i_src_data.
o_dma_drive  out  1  output-enable for the three buses above; high only in WRITE state.
i_dma_active  in  1  from GfxDma o_active.

Behaviour:
Reset is synchronous, active-high, one clock, single i_clk domain.
Reset values:
- FIFO empty; o_level 0; o_empty 1; o_full 0; o_overflow 0; o_busy 0.
- o_dma_ce_b 1; o_dma_we_b 1; o_dma_drive 0; o_dma_addr 0; o_dma_data 0.
- Staging bytes 0x00, except byte 6 (MASK) = 0xFF.

CPU writes:
- A write to addr 0–6 updates the staging byte only.
- A write to addr 7 stores the byte as staging[7], then pushes {staging[0..6], i_cpu_data} into the FIFO.
- Staging bytes persist after a push, so a following descriptor only needs to rewrite the bytes that change.
- Push when full is dropped and sets o_overflow. Exception: a pop in the same cycle frees a slot, and the push is accepted.
- Write to CTRL (addr 8): bit0 = 1 empties all queued (not yet popped) entries; bit1 = 1 clears o_overflow. Other bits are ignored.
- If a flush and a push happen in the same cycle, the flush applies first and the push is kept (o_level becomes 1).
- Addresses 9–15 are ignored.

Sequencer FSM:
- IDLE: if the FIFO is non-empty and i_dma_active = 0, pop the head into the shadow descriptor, clear idx, go to WRITE. Pop occurs on this edge.
- WRITE: for idx = 0..7, one byte per cycle:
  - o_dma_drive = 1, o_dma_ce_b = 0, o_dma_we_b = 0;
  - o_dma_addr = idx; o_dma_data = shadow[idx].
  - After idx = 7, go to WAIT_START, with ce_b, we_b and drive deasserted on that same edge.
  - Exactly 8 consecutive cycles; STATE is always written last.
- WAIT_START: go to WAIT_DONE when i_dma_active = 1. If START_TIMEOUT cycles elapse without it, go to IDLE (guards against a lost start).
- WAIT_DONE: go to IDLE when i_dma_active = 0.
- Minimum spacing between consecutive STATE writes is 8 + 1 + 1 + DMA run cycles.

Outputs:
- All outputs are registered.
- o_level, o_full and o_empty reflect pushes and pops made on the previous edge.

Boundary conditions:
- Pointers wrap modulo DEPTH; occupancy is tracked with a separate DEPTH_LOG2+1 bit counter.
- A flush does not abort the in-flight descriptor; the current WRITE or WAIT sequence completes.
- Reset mid-WRITE: bus outputs are released on the reset edge, and the DMA may be left with partially written registers. This is acceptable because STATE was not written.
- i_dma_active high in IDLE (CPU drove the DMA directly): the sequencer holds in IDLE until it falls.

Decomposition:
Shared package gfx_pkg holds:
- DMA register address constants: SRC_L = 0, SRC_H = 1, DST_L = 2, DST_H = 3, WIDTH = 4, HEIGHT = 5, MASK = 6, STATE = 7.
- CTRL address 8 and the CTRL bit positions.
- FSM state encoding (IDLE, WRITE, WAIT_START, WAIT_DONE).

Sub-module gfx_desc_fifo: a synchronous 64-bit × DEPTH FIFO with push, pop, flush, level, full and empty. The sequencer and staging registers stay in the top module.

Test Plan:
1. Reset, then write bytes 0–7 = 10,02,40,30,07,0F,FF,01, with i_dma_active low → o_level goes to 1. Next cycle WRITE issues addr 0..7 with exactly those data on 8 consecutive cycles, we_b low throughout. o_level goes to 0 at the pop.
2. Same descriptor, DMA model raises active 1 cycle after STATE and holds it for 50 cycles → sequencer sits in WAIT_DONE and o_busy = 1. Queue a second descriptor meanwhile → its WRITE begins exactly 1 cycle after active falls, never earlier.
3. Fill DEPTH = 4 while active is held high, then push a 5th → o_full = 1, o_overflow = 1, o_level stays 4. CTRL write 0x02 → o_overflow = 0.
4. Queue full, with a pop and a STATE push on the same edge → push accepted, o_level stays 4, no overflow.
5. Two queued entries plus one in flight, CTRL write 0x01 → o_level = 0. The in-flight descriptor finishes its writes and the sequencer returns to IDLE without another WRITE.
6. Assert i_rst at WRITE idx = 3 → next edge o_dma_ce_b = 1, o_dma_we_b = 1, o_dma_drive = 0, FIFO empty, and no addr 7 write ever observed.
